// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA layer pipeline.
//   LAYER_NUM  : default number of drawing layers
//   RGB_W      : width of the rgb channel
//   CNT_W      : width of hcount/vcount
//   BLANK_RGB  : colour shown while blanking
//   COLL_CNT_W : width of the per-frame collision counter
//   arb_state_t: mask-reconfiguration FSM states
package vga_pkg;
    localparam int LAYER_NUM  = 4;
    localparam int RGB_W      = 12;
    localparam int CNT_W      = 11;
    localparam int COLL_CNT_W = 20;
    localparam logic [RGB_W-1:0] BLANK_RGB = 12'h000;

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_APPLY} arb_state_t;
endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between pipeline stages.
//   in  : consumer view (all signals inputs)
//   out : producer view (all signals outputs)
interface vga_if;
    import vga_pkg::*;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/layer_prio_enc.sv
// Fixed-priority encoder, bit 0 highest priority.
//   req_i     : request vector
//   grant_o   : one-hot grant of the lowest set request bit (0 if none)
//   any_hit_o : at least one request set
module layer_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         any_hit_o
);
    // Scan from the lowest-priority end so the highest-priority hit overwrites.
    always_comb begin
        grant_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
    end

    assign any_hit_o = |req_i;
endmodule

// File: rtl/layer_arbiter.sv
// Layer arbiter: picks one pixel source per clock between the background
// and NUM_LAYERS drawing layers (layer 0 highest priority), with a per-layer
// enable mask that is updated only at the start of vertical blanking.
// All vga_out fields are delayed 2 cycles relative to vga_in.
//   clk, rst      : pixel clock, asynchronous active-high reset
//   vga_in        : upstream timing + background rgb
//   vga_out       : delayed timing + arbitrated rgb
//   layer_hit     : per-layer opaque-pixel flags aligned with vga_in
//   layer_rgb     : per-layer colours aligned with vga_in
//   cfg_valid/cfg_ready/cfg_mask : enable-mask offer handshake
//   cfg_done      : one-cycle pulse when the new mask becomes active
//   active_mask   : currently applied enable mask
//   collision_cnt : multi-layer-hit count of the previous frame
// Build option: define LAYER_ARB_STATS_EN to enable the collision counter;
// otherwise collision_cnt is tied to 0.
module layer_arbiter
    import vga_pkg::*;
#(
    parameter int                     NUM_LAYERS = LAYER_NUM,
    parameter logic [NUM_LAYERS-1:0]  EN_RESET   = {{(NUM_LAYERS-1){1'b0}}, 1'b1},
    parameter logic [RGB_W-1:0]       BLANK_RGB  = vga_pkg::BLANK_RGB
) (
    input  logic                              clk,
    input  logic                              rst,
    vga_if.in                                 vga_in,
    vga_if.out                                vga_out,
    input  logic [NUM_LAYERS-1:0]             layer_hit,
    input  logic [NUM_LAYERS-1:0][RGB_W-1:0]  layer_rgb,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [NUM_LAYERS-1:0]             cfg_mask,
    output logic                              cfg_done,
    output logic [NUM_LAYERS-1:0]             active_mask,
    output logic [COLL_CNT_W-1:0]             collision_cnt
);
    // ---------------- arbitration ----------------
    logic [NUM_LAYERS-1:0] eff_hit, grant;
    logic                  any_hit;
    logic [RGB_W-1:0]      win_rgb;

    assign eff_hit = layer_hit & active_mask;

    layer_prio_enc #(.N(NUM_LAYERS)) u_enc (
        .req_i     (eff_hit),
        .grant_o   (grant),
        .any_hit_o (any_hit)
    );

    always_comb begin
        win_rgb = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (grant[i]) win_rgb = win_rgb | layer_rgb[i];
        end
    end

    // ---------------- stage 1 ----------------
    logic             s1_any_q, s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q;
    logic [RGB_W-1:0] s1_win_q, s1_bg_q;
    logic [CNT_W-1:0] s1_hcount_q, s1_vcount_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_any_q    <= 1'b0;
            s1_win_q    <= '0;
            s1_bg_q     <= '0;
            s1_hcount_q <= '0;
            s1_vcount_q <= '0;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
        end else begin
            s1_any_q    <= any_hit;
            s1_win_q    <= win_rgb;
            s1_bg_q     <= vga_in.rgb;
            s1_hcount_q <= vga_in.hcount;
            s1_vcount_q <= vga_in.vcount;
            s1_hsync_q  <= vga_in.hsync;
            s1_vsync_q  <= vga_in.vsync;
            s1_hblnk_q  <= vga_in.hblnk;
            s1_vblnk_q  <= vga_in.vblnk;
        end
    end

    // ---------------- stage 2 (output register) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out.rgb    <= '0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
        end else begin
            if (s1_hblnk_q | s1_vblnk_q) vga_out.rgb <= BLANK_RGB;
            else if (s1_any_q)           vga_out.rgb <= s1_win_q;
            else                         vga_out.rgb <= s1_bg_q;
            vga_out.hcount <= s1_hcount_q;
            vga_out.vcount <= s1_vcount_q;
            vga_out.hsync  <= s1_hsync_q;
            vga_out.vsync  <= s1_vsync_q;
            vga_out.hblnk  <= s1_hblnk_q;
            vga_out.vblnk  <= s1_vblnk_q;
        end
    end

    // ---------------- frame boundary detect ----------------
    logic vblnk_q, vb_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vblnk_q <= 1'b0;
        else     vblnk_q <= vga_in.vblnk;
    end

    assign vb_rise = vga_in.vblnk & ~vblnk_q;

    // ---------------- mask reconfiguration FSM ----------------
    arb_state_t            state_q, state_d;
    logic [NUM_LAYERS-1:0] shadow_q, shadow_d, active_q, active_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= EN_RESET;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // A request arriving in IDLE is only captured; the vb_rise of that same
    // cycle is not used, so the mask waits for the next frame boundary.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    shadow_d = cfg_mask;
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (vb_rise) begin
                    active_d = shadow_q;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cfg_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active_mask = active_q;

    // ---------------- collision statistics ----------------
`ifdef LAYER_ARB_STATS_EN
    logic [NUM_LAYERS-1:0] unused_rest_grant;
    logic                  multi_hit;
    logic [COLL_CNT_W-1:0] coll_q, coll_last_q;

    // Removing the winner leaves a hit only if two or more layers hit.
    layer_prio_enc #(.N(NUM_LAYERS)) u_enc_rest (
        .req_i     (eff_hit & ~grant),
        .grant_o   (unused_rest_grant),
        .any_hit_o (multi_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q      <= '0;
            coll_last_q <= '0;
        end else if (vb_rise) begin
            coll_last_q <= coll_q;
            coll_q      <= '0;
        end else if (multi_hit && !(vga_in.hblnk | vga_in.vblnk) && (coll_q != '1)) begin
            coll_q <= coll_q + COLL_CNT_W'(1);
        end
    end

    assign collision_cnt = coll_last_q;
`else
    assign collision_cnt = '0;
`endif
endmodule

// File: tb/tb_layer_arbiter.sv
module tb_layer_arbiter;
    import vga_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            layer_hit;
    logic [3:0][RGB_W-1:0] layer_rgb;
    logic                  cfg_valid, cfg_ready, cfg_done;
    logic [3:0]            cfg_mask, active_mask;
    logic [COLL_CNT_W-1:0] collision_cnt;

    vga_if vin();
    vga_if vout();

    int n_tests = 0;
    int n_fail  = 0;

    layer_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .vga_in        (vin),
        .vga_out       (vout),
        .layer_hit     (layer_hit),
        .layer_rgb     (layer_rgb),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mask      (cfg_mask),
        .cfg_done      (cfg_done),
        .active_mask   (active_mask),
        .collision_cnt (collision_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        layer_hit  = '0;
        layer_rgb  = '0;
        cfg_valid  = 1'b0;
        cfg_mask   = '0;
        vin.hcount = '0;
        vin.vcount = '0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = '0;
        step();
        step();

        // reset state
        chk("rst_rgb",    vout.rgb, 32'h0);
        chk("rst_hcount", vout.hcount, 32'h0);
        chk("rst_ready",  cfg_ready, 32'h1);
        chk("rst_done",   cfg_done, 32'h0);
        chk("rst_mask",   active_mask, 32'h1);
        chk("rst_coll",   collision_cnt, 32'h0);
        rst = 1'b0;

        // layer 0 wins over layer 1, timing delayed by 2
        layer_rgb[0] = 12'hF00;
        layer_rgb[1] = 12'h00F;
        layer_rgb[2] = 12'h0FF;
        layer_rgb[3] = 12'hFFF;
        vin.rgb      = 12'h0F0;
        vin.hcount   = 11'd5;
        vin.vcount   = 11'd7;
        vin.hsync    = 1'b1;
        layer_hit    = 4'b0011;
        step();
        chk("lat1_hcount", vout.hcount, 32'h0);
        chk("lat1_hsync",  vout.hsync, 32'h0);
        step();
        chk("l0_rgb",    vout.rgb, 32'hF00);
        chk("l0_hcount", vout.hcount, 32'd5);
        chk("l0_vcount", vout.vcount, 32'd7);
        chk("l0_hsync",  vout.hsync, 32'h1);

        // disabled layer -> background, then blanked
        layer_hit = 4'b0010;
        step(); step();
        chk("dis_bg", vout.rgb, 32'h0F0);
        vin.hblnk = 1'b1;
        step(); step();
        chk("hblnk_rgb", vout.rgb, 32'h000);
        vin.hblnk = 1'b0;
        layer_hit = 4'b0000;
        step(); step();
        chk("nohit_bg", vout.rgb, 32'h0F0);

        // mask update mid-frame, applied on vb_rise
        cfg_mask  = 4'b0110;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("pend_ready", cfg_ready, 32'h0);
        chk("pend_mask",  active_mask, 32'h1);
        step(); step();
        chk("pend_mask2", active_mask, 32'h1);
        chk("pend_done",  cfg_done, 32'h0);
        vin.vblnk = 1'b1;
        step();
        chk("apply_done",  cfg_done, 32'h1);
        chk("apply_mask",  active_mask, 32'h6);
        chk("apply_ready", cfg_ready, 32'h0);
        step();
        chk("idle_done",  cfg_done, 32'h0);
        chk("idle_ready", cfg_ready, 32'h1);
        vin.vblnk = 1'b0;
        layer_hit = 4'b0011;
        step(); step();
        chk("m6_l1_rgb", vout.rgb, 32'h00F);
        layer_hit = 4'b0001;
        step(); step();
        chk("m6_bg_rgb", vout.rgb, 32'h0F0);

        // request coincident with vb_rise waits a whole frame
        vin.vblnk = 1'b1;
        cfg_mask  = 4'b1111;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("coin_ready", cfg_ready, 32'h0);
        chk("coin_mask",  active_mask, 32'h6);
        step();
        chk("coin_done",  cfg_done, 32'h0);
        chk("coin_mask2", active_mask, 32'h6);
        vin.vblnk = 1'b0;
        step();
        vin.vblnk = 1'b1;
        step();
        chk("coin_apply_done", cfg_done, 32'h1);
        chk("coin_apply_mask", active_mask, 32'hF);

        // 37 visible collision cycles in one frame
        vin.vblnk = 1'b0;
        layer_hit = 4'b0011;
        for (int i = 0; i < 37; i++) step();
        layer_hit = 4'b0000;
        vin.vblnk = 1'b1;
        step();
`ifdef LAYER_ARB_STATS_EN
        chk("coll_cnt", collision_cnt, 32'd37);
`else
        chk("coll_cnt", collision_cnt, 32'd0);
`endif

        // all layers hitting -> layer 0; upper pair -> layer 2
        vin.vblnk = 1'b0;
        layer_hit = 4'b1111;
        step(); step();
        chk("all_hit_rgb", vout.rgb, 32'hF00);
        layer_hit = 4'b1100;
        step(); step();
        chk("hi_hit_rgb", vout.rgb, 32'h0FF);

        // reset while pending discards the shadow mask
        cfg_mask  = 4'b0010;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("rp_ready", cfg_ready, 32'h0);
        rst = 1'b1;
        #1;
        chk("rp_mask",  active_mask, 32'h1);
        chk("rp_ready_async", cfg_ready, 32'h1);
        chk("rp_done",  cfg_done, 32'h0);
        chk("rp_rgb",   vout.rgb, 32'h0);
        #2;
        rst = 1'b0;
        vin.vblnk = 1'b1;
        step();
        chk("rp_vb_done", cfg_done, 32'h0);
        chk("rp_vb_mask", active_mask, 32'h1);
        step();
        chk("rp_vb_done2", cfg_done, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
